// File: rtl/deferred_step_ctrl.sv
// Batches per-core difftest commit steps into n-step host requests and periodically
// polls the deferred comparison result, halting all stepping on the first mismatch.
module deferred_step_ctrl #(
  parameter int NUM_CORES       = 2,
  parameter int STEP_WIDTH      = 8,
  parameter int ACC_WIDTH       = 32,
  parameter int FLUSH_THRESHOLD = 64,
  parameter int FETCH_INTERVAL  = 5000
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0]                 step,
  output logic                                            req_valid,
  input  logic                                            req_ready,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] req_core,
  output logic [ACC_WIDTH-1:0]                            req_nstep,
  output logic                                            fetch_req,
  input  logic                                            fetch_ack,
  input  logic                                            fetch_result,
  output logic                                            simv_result,
  output logic                                            overflow
);
  localparam int CORE_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TIMER_W = $clog2(FETCH_INTERVAL);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(FETCH_INTERVAL - 1);
  localparam logic [ACC_WIDTH-1:0] THRESH     = ACC_WIDTH'(FLUSH_THRESHOLD);

  typedef enum logic [1:0] {COUNT, DRAIN, FETCH, DONE} fetch_state_t;

  // Returns {saturated, value}; the value clamps to all-ones on carry out.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0]  a,
                                                 input logic [STEP_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, a} + {{(ACC_WIDTH - STEP_WIDTH + 1){1'b0}}, b};
    if (sum[ACC_WIDTH]) sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
    else                sat_add = sum;
  endfunction

  logic [ACC_WIDTH-1:0] acc     [NUM_CORES];
  logic [ACC_WIDTH-1:0] acc_nxt [NUM_CORES];
  logic [ACC_WIDTH:0]   add_res;
  logic [NUM_CORES-1:0] eligible, nonzero, grant_vec, sat_vec, expiry_mask;
  logic [NUM_CORES-1:0] drain_mask, drain_mask_nxt;
  logic [CORE_W-1:0]    last_grant, grant_idx, cand;
  logic [ACC_WIDTH-1:0] grant_nstep;
  logic                 handshake, slot_free, grant_any, simv_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  fetch_state_t         state, state_nxt;

  assign handshake = req_valid & req_ready;
  assign slot_free = ~req_valid | handshake;

  always_comb begin
    nonzero  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      nonzero[i]  = (acc[i] != '0);
      eligible[i] = (acc[i] >= THRESH) || (drain_mask[i] && nonzero[i]);
    end
  end

  // Round robin: first eligible core strictly after the last one granted.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (slot_free && !simv_result) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        cand = CORE_W'((int'(last_grant) + k) % NUM_CORES);
        if (!grant_any && eligible[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign grant_nstep = acc[grant_idx];

  // A granted core restarts from this cycle's step so nothing is lost.
  always_comb begin
    grant_vec = '0;
    sat_vec   = '0;
    add_res   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      acc_nxt[i] = acc[i];
      if (grant_any && (grant_idx == CORE_W'(i))) begin
        grant_vec[i] = 1'b1;
        acc_nxt[i]   = {{(ACC_WIDTH - STEP_WIDTH){1'b0}}, step[i*STEP_WIDTH +: STEP_WIDTH]};
      end else begin
        add_res    = sat_add(acc[i], step[i*STEP_WIDTH +: STEP_WIDTH]);
        acc_nxt[i] = add_res[ACC_WIDTH-1:0];
        sat_vec[i] = add_res[ACC_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) acc[i] <= '0;
      overflow <= 1'b0;
    end else if (!simv_result) begin
      for (int i = 0; i < NUM_CORES; i++) acc[i] <= acc_nxt[i];
      if (|sat_vec) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_valid  <= 1'b0;
      req_core   <= '0;
      req_nstep  <= '0;
      last_grant <= CORE_W'(NUM_CORES - 1);
    end else if (grant_any) begin
      req_valid  <= 1'b1;
      req_core   <= grant_idx;
      req_nstep  <= grant_nstep;
      last_grant <= grant_idx;
    end else if (handshake) begin
      req_valid  <= 1'b0;
    end
  end

  // Cores granted in the expiry cycle already shipped their steps, so they are not drained.
  assign expiry_mask = nonzero & ~grant_vec;

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    drain_mask_nxt = drain_mask & ~grant_vec;
    simv_nxt       = simv_result;
    fetch_req      = 1'b0;
    case (state)
      COUNT: begin
        if (timer == TIMER_LAST) begin
          timer_nxt      = '0;
          drain_mask_nxt = expiry_mask;
          state_nxt      = (expiry_mask == '0) ? FETCH : DRAIN;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DRAIN: begin
        if ((drain_mask == '0) && slot_free) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          simv_nxt  = simv_result | fetch_result;
          state_nxt = fetch_result ? DONE : COUNT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= COUNT;
      timer       <= '0;
      drain_mask  <= '0;
      simv_result <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      drain_mask  <= drain_mask_nxt;
      simv_result <= simv_nxt;
    end
  end

endmodule

// File: doc/deferred_step_ctrl.md
# deferred_step_ctrl

Multi-core, parametrised controller for deferred difftest result checking. It accumulates per-core commit step counts and emits batched n-step requests to the host-side checker over a valid/ready channel. It periodically polls the deferred comparison result over a request/ack channel and latches a sticky failure flag that halts further stepping. It sits between the per-core difftest step outputs and the simulator-side DPI bridge, replacing a single-core, fixed-interval, unbatched controller.

## Interface
Parameters:
- NUM_CORES, 2, number of cores; each core has its own accumulator.
- STEP_WIDTH, 8, width of each per-core step input.
- ACC_WIDTH, 32, width of accumulators and of req_nstep; must be > STEP_WIDTH.
- FLUSH_THRESHOLD, 64, accumulator value at or above which a core is eligible for a request.
- FETCH_INTERVAL, 5000, cycles between result polls; must be ≥ 2.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- step  in  NUM_CORES*STEP_WIDTH  per-core steps this cycle; core i occupies bits [i*STEP_WIDTH +: STEP_WIDTH].
- req_valid  out  1  n-step request pending.
- req_ready  in  1  host accepts the request.
- req_core  out  max(1,$clog2(NUM_CORES))  core index of the request.
- req_nstep  out  ACC_WIDTH  number of steps in the request, always nonzero.
- fetch_req  out  1  result poll pending.
- fetch_ack  in  1  poll completed this cycle.
- fetch_result  in  1  mismatch flag; sampled only when fetch_ack is high.
- simv_result  out  1  sticky mismatch detected.
- overflow  out  1  sticky: some accumulator saturated.

## Operation
- Accumulate: every cycle, acc[i] <= acc[i] + step[i], unless core i is granted this cycle, in which case acc[i] <= step[i]. No step is ever lost. The sum saturates at 2^ACC_WIDTH−1 and sets overflow.
- Eligibility: core i is eligible when acc[i] ≥ FLUSH_THRESHOLD, or when it is in drain_mask and acc[i] ≠ 0.
- Request channel: a grant is allowed when req_valid is low or the request handshakes this cycle. A round-robin arbiter then grants the lowest eligible index strictly after the last granted core, wrapping. The grant loads req_core and req_nstep from the pre-update acc and sets req_valid.
- While req_valid is high and req_ready is low, req_core and req_nstep hold stable.
- Fetch FSM states:
  - COUNT: the timer increments each cycle. When timer == FETCH_INTERVAL−1: timer <= 0, drain_mask <= set of cores with acc ≠ 0, and the FSM goes to DRAIN. If the mask is empty, go to FETCH directly.
  - DRAIN: each grant clears its core's bit in drain_mask. When the mask is empty and no request is outstanding (or the request handshakes this cycle), go to FETCH.
  - FETCH: fetch_req is high. On fetch_ack, simv_result <= fetch_result (OR-ed into the sticky flag). Then go to DONE if fetch_result is 1, else go to COUNT.
  - DONE: terminal until reset.
- Once simv_result is 1, no new grants are made and accumulators hold. A req_valid already outstanding stays asserted until it handshakes.
- fetch_ack while not in FETCH is ignored.
- Reset mid-transaction drops any outstanding request or poll with no handshake.

## Timing
- Reset values: all outputs 0, acc = 0, timer = 0, drain_mask = 0, FSM = COUNT, last-granted = NUM_CORES−1 (so core 0 wins first).
- Step input at cycle t appears in acc at t+1. A threshold crossing at t+1 produces req_valid high at t+2.
- Back-to-back grants are possible, one per cycle, when req_ready is held high.
- The first poll asserts fetch_req no earlier than FETCH_INTERVAL cycles after reset deassertion, plus drain time.
- simv_result rises in the cycle after the fetch_ack with fetch_result = 1.
- fetch_req deasserts in the cycle after fetch_ack.

## Test plan
- NUM_CORES=2, FLUSH_THRESHOLD=64: step0=16 for 4 cycles, req_ready=1 -> single request core=0 nstep=64 two cycles after the 4th step; acc0 then holds the concurrent step only.
- Both cores cross threshold in the same cycle, req_ready=1 -> core 0 granted first, core 1 next cycle; a subsequent tie is granted to core 0 again only after core 1 has been served (round robin).
- req_ready=0 for 10 cycles with req_valid high while steps continue -> req_core and req_nstep stable; the accumulator keeps summing; the next request carries the full sum.
- FETCH_INTERVAL=8, acc0=5, acc1=0 at expiry -> DRAIN issues core=0 nstep=5, then fetch_req rises; fetch_ack with fetch_result=0 -> back to COUNT, simv_result stays 0.
- Poll returns fetch_result=1 while a request is outstanding -> simv_result=1 next cycle; the outstanding request completes on req_ready; no further req_valid; fetch_req never reasserts.
- ACC_WIDTH=9, step0=255 every cycle, req_ready=0 -> acc saturates at 511 and overflow=1; a mid-run reset clears all outputs to 0 within one cycle.
